// File: rtl/serial_comp_ctrl.sv
// serial_comp_ctrl: compares two WIDTH-bit operands serially, MSB digit first,
// through one external 2-bit magnitude-comparator slice.
// The latched verdict is reported with a busy/done handshake.
// Optional build macro: SERIAL_COMP_EARLY_EXIT_EN.
//   Defined:   the compare finishes at the first unequal digit.
//   Undefined: all digits are always scanned, so timing does not depend on the data.
module serial_comp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeb,
  output logic             agb,
  output logic             alb,
  output logic [1:0]       slice_a,
  output logic [1:0]       slice_b,
  input  logic             slice_aeb,
  input  logic             slice_agb,
  input  logic             slice_alb
);

  localparam int ND = WIDTH / 2;
  localparam int IW = (ND > 1) ? $clog2(ND) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_cap_reg, b_cap_reg;
  logic [IW-1:0]    idx_reg;
  logic             aeb_reg, agb_reg, alb_reg;

  // Digit views of the captured operands, indexed by digit number.
  logic [1:0] a_dig [ND];
  logic [1:0] b_dig [ND];

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dig
      assign a_dig[gi] = a_cap_reg[2*gi +: 2];
      assign b_dig[gi] = b_cap_reg[2*gi +: 2];
    end
  endgenerate

  // Slice verdict for the current digit.
  // Greater wins over less; no flag at all counts as equal, so the slice's
  // equal flag carries no extra information.
  logic dig_gt, dig_lt, last_dig, decided;
  logic slice_unused;
  assign slice_unused = slice_aeb;
  assign dig_gt   = slice_agb;
  assign dig_lt   = !slice_agb && slice_alb;
  assign last_dig = (idx_reg == '0);
  assign decided  = agb_reg || alb_reg;

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
      RUN:  if (dig_gt || dig_lt || last_dig) state_next = DONE;
`else
      RUN:  if (last_dig) state_next = DONE;
`endif
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Operand capture, digit index and verdict accumulation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_cap_reg <= '0;
      b_cap_reg <= '0;
      idx_reg   <= '0;
      aeb_reg   <= 1'b0;
      agb_reg   <= 1'b0;
      alb_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            a_cap_reg <= a;
            b_cap_reg <= b;
            idx_reg   <= IW'(ND - 1);
            aeb_reg   <= 1'b0;
            agb_reg   <= 1'b0;
            alb_reg   <= 1'b0;
          end
        end
        RUN: begin
`ifdef SERIAL_COMP_EARLY_EXIT_EN
          if (dig_gt)        agb_reg <= 1'b1;
          else if (dig_lt)   alb_reg <= 1'b1;
          else if (last_dig) aeb_reg <= 1'b1;
          else               idx_reg <= idx_reg - 1'b1;
`else
          // The first unequal digit sticks; later digits are only walked.
          if (!decided) begin
            if (dig_gt)        agb_reg <= 1'b1;
            else if (dig_lt)   alb_reg <= 1'b1;
            else if (last_dig) aeb_reg <= 1'b1;
          end
          if (!last_dig) idx_reg <= idx_reg - 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  // Outputs: the slice sees the current digit only while running.
  always_comb begin
    busy    = (state_reg != IDLE);
    done    = (state_reg == DONE);
    aeb     = aeb_reg;
    agb     = agb_reg;
    alb     = alb_reg;
    slice_a = 2'b00;
    slice_b = 2'b00;
    if (state_reg == RUN) begin
      slice_a = a_dig[idx_reg];
      slice_b = b_dig[idx_reg];
    end
  end

endmodule
